bist_sig_checker: RTL and testbench
===================================

BIST_SIG_CHECKER -- requirements
Module: bist_sig_checker

Interface
REQ-001 SHALL have parameter SIG_W, default 74: signature width, matching the MISR width.
REQ-002 SHALL have parameter PATTERN_COUNT, default 256: number of clocks the CUT/MISR run per session (range 1..65535).
REQ-003 SHALL have parameter PIPE_LAT, default 2: flush clocks between the end of RUN and signature sampling (range 0..15).
REQ-004 SHALL have parameter CLR_CYCLES, default 2: clocks that cut_reset is held high at session start (range 1..15).
REQ-005 SHALL have port clk, input, 1: clock; all logic on the rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port start, input, 1: single-cycle session request.
REQ-008 SHALL have port misr, input, SIG_W: signature register output of the CUT/MISR stage.
REQ-009 SHALL have port golden, input, SIG_W: expected signature, static during a session.
REQ-010 SHALL have port cut_reset, output, 1: drives the reset of the CUT and MISR.
REQ-011 SHALL have port busy, output, 1: high in CLR, RUN, FLUSH and CMP.
REQ-012 SHALL have port done, output, 1: high in DONE.
REQ-013 SHALL have port pass, output, 1: captured signature equals golden.
REQ-014 SHALL have port fail, output, 1: captured signature differs from golden.
REQ-015 SHALL have port sig_cap, output, SIG_W: misr value captured in CMP.
REQ-016 SHALL have port diff_cnt, output, 7: number of mismatching bits (see Configuration).

Function
REQ-017 SHALL implement states IDLE, CLR, RUN, FLUSH, CMP, DONE.
REQ-018 IDLE: on start=1, go to CLR next clock; otherwise stay.
REQ-019 CLR: cut_reset=1 for exactly CLR_CYCLES clocks, then go to RUN.
REQ-020 RUN: cut_reset=0 for exactly PATTERN_COUNT clocks, then go to FLUSH.
REQ-021 FLUSH: stay exactly PIPE_LAT clocks; PIPE_LAT=0 goes directly RUN->CMP.
REQ-022 CMP: one clock; in it sig_cap<=misr, pass<=(misr==golden), fail<=(misr!=golden); go to DONE.
REQ-023 DONE: hold sig_cap/pass/fail/diff_cnt; start=1 clears pass, fail and diff_cnt and goes to CLR (restart).
REQ-024 pass and fail SHALL never both be 1; both are 0 outside DONE.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 cut_reset SHALL be registered and glitch-free; it is high only in CLR.
REQ-027 The single phase counter SHALL be wide enough for max(PATTERN_COUNT, CLR_CYCLES, PIPE_LAT) and reload on every state entry.
REQ-028 Session length from start sample to done=1 SHALL be 1+CLR_CYCLES+PATTERN_COUNT+PIPE_LAT+1 clocks.

Reset
REQ-029 reset=1 SHALL force state IDLE and counter=0, cut_reset=0, busy=0, done=0, pass=0, fail=0, sig_cap=0, diff_cnt=0.
REQ-030 reset SHALL take priority over start; reset mid-session SHALL abort with no partial result.

Configuration
REQ-031 With macro BIST_SIG_DIFF_EN defined, diff_cnt SHALL be registered in CMP as the popcount of (misr XOR golden).
REQ-032 Without BIST_SIG_DIFF_EN, diff_cnt SHALL be tied to 0 and no popcount logic SHALL be synthesized.

Structure
REQ-033 A shared package bist_pkg SHALL hold the state enum type (bist_state_t), SIG_W default 74, and the diff_cnt width 7.
REQ-034 The popcount SHALL be a sub-module, bist_popcount, instantiated only under BIST_SIG_DIFF_EN.

Verification
REQ-035 PATTERN_COUNT=4, PIPE_LAT=2, CLR_CYCLES=2; start pulse -> cut_reset high 2 clocks, done rises 10 clocks after start sample.
REQ-036 misr=golden=74'h0ABC at CMP -> pass=1, fail=0, sig_cap=74'h0ABC, diff_cnt=0.
REQ-037 golden=0, misr=74'h7 at CMP -> fail=1, pass=0, diff_cnt=3 (with macro) or 0 (without).
REQ-038 start pulsed during RUN -> ignored; done timing unchanged.
REQ-039 reset asserted during FLUSH -> next clock IDLE, all outputs 0; a later start runs a full session.
REQ-040 start in DONE -> pass/fail cleared next clock, cut_reset high, new session completes.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST signature checker.
package bist_pkg;

  localparam int BIST_SIG_W  = 74;
  localparam int BIST_DIFF_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RUN,
    FLUSH,
    CMP,
    DONE
  } bist_state_t;

endpackage

// File: rtl/bist_popcount.sv
// Counts the set bits of a vector; used to report how many signature bits mismatch.
module bist_popcount
  import bist_pkg::*;
#(
  parameter int W = BIST_SIG_W
) (
  input  logic [W-1:0]           vec,
  output logic [BIST_DIFF_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + BIST_DIFF_W'(vec[i]);
    end
  end

endmodule

// File: rtl/bist_sig_checker.sv
// Sequences one BIST session (clear, run, flush, compare) and reports the MISR verdict.
// Define BIST_SIG_DIFF_EN to also report the number of mismatching signature bits.
module bist_sig_checker
  import bist_pkg::*;
#(
  parameter int SIG_W         = BIST_SIG_W,
  parameter int PATTERN_COUNT = 256,
  parameter int PIPE_LAT      = 2,
  parameter int CLR_CYCLES    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [SIG_W-1:0]       misr,
  input  logic [SIG_W-1:0]       golden,
  output logic                   cut_reset,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   fail,
  output logic [SIG_W-1:0]       sig_cap,
  output logic [BIST_DIFF_W-1:0] diff_cnt
);

  localparam int MAX_A   = (PATTERN_COUNT > CLR_CYCLES) ? PATTERN_COUNT : CLR_CYCLES;
  localparam int MAX_CNT = (MAX_A > PIPE_LAT) ? MAX_A : PIPE_LAT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  // Each phase loads (length - 1) on entry and exits when the counter reaches zero.
  localparam logic [CNT_W-1:0] CLR_LOAD   = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LOAD   = CNT_W'(PATTERN_COUNT - 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'((PIPE_LAT > 0) ? (PIPE_LAT - 1) : 0);

  bist_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cut_reset <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cut_reset <= (state_d == CLR);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLR;
          cnt_d   = CLR_LOAD;
        end
      end
      CLR: begin
        if (cnt_q == '0) begin
          state_d = RUN;
          cnt_d   = RUN_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          if (PIPE_LAT == 0) begin
            state_d = CMP;
            cnt_d   = '0;
          end else begin
            state_d = FLUSH;
            cnt_d   = FLUSH_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = CMP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CMP: begin
        state_d = DONE;
        cnt_d   = '0;
      end
      DONE: begin
        if (start) begin
          state_d = CLR;
          cnt_d   = CLR_LOAD;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == CLR) || (state_q == RUN) || (state_q == FLUSH) || (state_q == CMP);
  assign done = (state_q == DONE);

  // The verdict is only valid in DONE; a restart drops it before the next session begins.
  always_ff @(posedge clk) begin
    if (reset) begin
      pass    <= 1'b0;
      fail    <= 1'b0;
      sig_cap <= '0;
    end else if (state_q == CMP) begin
      sig_cap <= misr;
      pass    <= (misr == golden);
      fail    <= (misr != golden);
    end else if ((state_q == DONE) && start) begin
      pass <= 1'b0;
      fail <= 1'b0;
    end
  end

`ifdef BIST_SIG_DIFF_EN
  logic [BIST_DIFF_W-1:0] pop_cnt;

  bist_popcount #(
    .W(SIG_W)
  ) u_popcount (
    .vec  (misr ^ golden),
    .count(pop_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      diff_cnt <= '0;
    end else if (state_q == CMP) begin
      diff_cnt <= pop_cnt;
    end else if ((state_q == DONE) && start) begin
      diff_cnt <= '0;
    end
  end
`else
  assign diff_cnt = '0;
`endif

endmodule

// File: tb/tb_bist_sig_checker.sv
// Directed bench for bist_sig_checker: a table of signature sessions plus reset/restart corner cases.
module tb_bist_sig_checker;
  import bist_pkg::*;

  localparam int W = 74;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [W-1:0]           misr;
  logic [W-1:0]           golden;
  logic                   cut_reset;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic                   fail;
  logic [W-1:0]           sig_cap;
  logic [BIST_DIFF_W-1:0] diff_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bist_sig_checker #(
    .SIG_W        (W),
    .PATTERN_COUNT(4),
    .PIPE_LAT     (2),
    .CLR_CYCLES   (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .misr     (misr),
    .golden   (golden),
    .cut_reset(cut_reset),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail     (fail),
    .sig_cap  (sig_cap),
    .diff_cnt (diff_cnt)
  );

  typedef struct {
    logic [W-1:0] misr;
    logic [W-1:0] golden;
    logic         exp_pass;
    logic         exp_fail;
    int           exp_diff;
  } vec_t;

  vec_t vecs[6];

  function automatic int diff_expect(input int d);
`ifdef BIST_SIG_DIFF_EN
    return d;
`else
    return 0 * d;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // One session from the current negedge; returns latency and per-cycle observations.
  task automatic applyStimulus(input logic [W-1:0] m, input logic [W-1:0] g, input int glitch_at,
                               output int lat, output int clr_hi, output int busy_cnt,
                               output int first_dirty, output int pf_bad);
    @(negedge clk);
    misr   = m;
    golden = g;
    start  = 1'b1;
    lat = 0; clr_hi = 0; busy_cnt = 0; first_dirty = 0; pf_bad = 0;
    while (lat < 40) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (lat == glitch_at) start = 1'b1;
      if (cut_reset) clr_hi++;
      if (busy) busy_cnt++;
      if (lat == 1 && (pass || fail || done || diff_cnt != '0)) first_dirty = 1;
      if ((pass && fail) || ((pass || fail) && !done)) pf_bad = 1;
      if (done) break;
    end
    start = 1'b0;
  endtask

  task automatic runSession(input string tag, input logic [W-1:0] m, input logic [W-1:0] g,
                            input int glitch_at, input logic ep, input logic ef, input int ed);
    int lat, clr_hi, busy_cnt, first_dirty, pf_bad;
    applyStimulus(m, g, glitch_at, lat, clr_hi, busy_cnt, first_dirty, pf_bad);
    checkOutput({tag, "_latency"}, W'(lat), W'(10));
    checkOutput({tag, "_cut_reset_cycles"}, W'(clr_hi), W'(2));
    checkOutput({tag, "_busy_cycles"}, W'(busy_cnt), W'(9));
    checkOutput({tag, "_cleared_on_start"}, W'(first_dirty), W'(0));
    checkOutput({tag, "_pass_fail_exclusive"}, W'(pf_bad), W'(0));
    checkOutput({tag, "_pass"}, W'(pass), W'(ep));
    checkOutput({tag, "_fail"}, W'(fail), W'(ef));
    checkOutput({tag, "_sig_cap"}, sig_cap, m);
    checkOutput({tag, "_diff_cnt"}, W'(diff_cnt), W'(diff_expect(ed)));
  endtask

  initial begin
    logic [W-1:0] held;

    vecs[0] = '{misr: 74'h0ABC, golden: 74'h0ABC, exp_pass: 1'b1, exp_fail: 1'b0, exp_diff: 0};
    vecs[1] = '{misr: 74'h7, golden: 74'h0, exp_pass: 1'b0, exp_fail: 1'b1, exp_diff: 3};
    vecs[2] = '{misr: {W{1'b1}}, golden: {W{1'b1}}, exp_pass: 1'b1, exp_fail: 1'b0, exp_diff: 0};
    vecs[3] = '{misr: {W{1'b1}}, golden: 74'h0, exp_pass: 1'b0, exp_fail: 1'b1, exp_diff: 74};
    vecs[4] = '{misr: 74'h0, golden: {1'b1, 73'b0}, exp_pass: 1'b0, exp_fail: 1'b1, exp_diff: 1};
    vecs[5] = '{misr: 74'hF0, golden: 74'hFF, exp_pass: 1'b0, exp_fail: 1'b1, exp_diff: 4};

    reset  = 1'b1;
    start  = 1'b0;
    misr   = '0;
    golden = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_cut_reset", W'(cut_reset), W'(0));
    checkOutput("rst_busy", W'(busy), W'(0));
    checkOutput("rst_done", W'(done), W'(0));
    checkOutput("rst_pass_fail", W'({pass, fail}), W'(0));
    checkOutput("rst_sig_cap", sig_cap, '0);

    // Reset must win over a simultaneous start.
    start = 1'b1;
    @(negedge clk);
    checkOutput("rst_over_start_busy", W'(busy), W'(0));
    checkOutput("rst_over_start_cut_reset", W'(cut_reset), W'(0));
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      runSession($sformatf("vec%0d", i), vecs[i].misr, vecs[i].golden, 0,
                 vecs[i].exp_pass, vecs[i].exp_fail, vecs[i].exp_diff);
    end

    // Results hold in DONE even when misr moves afterwards.
    held = sig_cap;
    repeat (3) @(negedge clk);
    misr = ~misr;
    @(negedge clk);
    checkOutput("hold_sig_cap", sig_cap, held);
    checkOutput("hold_done", W'(done), W'(1));
    checkOutput("hold_fail", W'(fail), W'(1));

    // A start pulse while running must not disturb the session.
    runSession("glitch_run", 74'h0ABC, 74'h0ABC, 4, 1'b1, 1'b0, 0);

    // Abort in FLUSH, then a clean session afterwards.
    @(negedge clk);
    misr   = 74'h7;
    golden = 74'h0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("flush_busy", W'(busy), W'(1));
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", W'(busy), W'(0));
    checkOutput("abort_cut_reset", W'(cut_reset), W'(0));
    checkOutput("abort_done", W'(done), W'(0));
    checkOutput("abort_pass_fail", W'({pass, fail}), W'(0));
    checkOutput("abort_sig_cap", sig_cap, '0);
    checkOutput("abort_diff_cnt", W'(diff_cnt), W'(0));
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort_no_result", W'({done, pass, fail}), W'(0));
    runSession("after_abort", 74'h7, 74'h0, 0, 1'b0, 1'b1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
